// File: rtl/snn_pkg.sv
// Shared definitions for the SNN accelerator: binary32 field layout,
// neuron address / decay-rate widths and the leak-unit FSM states.
package snn_pkg;

   localparam int          SIGN_BIT = 31;
   localparam int          EXP_MSB  = 30;
   localparam int          EXP_LSB  = 23;
   localparam int          FRAC_W   = 23;
   localparam int          EXP_W    = 8;
   localparam int          MANT_W   = 24;
   localparam logic [7:0]  EXP_MAX  = 8'd255;
   localparam logic [7:0]  EXP_ZERO = 8'd0;

   localparam int          ADDR_W   = 12;
   localparam int          DECAY_W  = 5;

   // Shift amounts at or beyond the mantissa width leave the operand untouched.
   localparam logic [4:0]  DECAY_NO_EFFECT = 5'd24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      COMPUTE = 2'd2,
      HOLD    = 2'd3
   } decay_state_e;

   // Zero carrying the requested sign; used for every flush-to-zero path.
   function automatic logic [31:0] signed_zero(input logic sign);
      return {sign, 31'd0};
   endfunction

endpackage

// File: rtl/fp_decay_core.sv
// Combinational leak datapath: result = V * (1 - 2^-k) on binary32,
// implemented as truncating shift-subtract on the 24-bit mantissa with a
// single normalization step.
module fp_decay_core
   import snn_pkg::*;
(
   input  logic [31:0]        potential,
   input  logic [DECAY_W-1:0] decay_rate,
   output logic [31:0]        result
);

   logic              sign_s;
   logic [EXP_W-1:0]  exp_s;
   logic [MANT_W-1:0] mant_s;
   logic [MANT_W-1:0] shifted_s;
   logic [MANT_W-1:0] diff_s;
   logic [FRAC_W-1:0] norm_frac_s;
   logic [EXP_W-1:0]  norm_exp_s;

   // Shift-subtract, normalize, then select the special-case result by priority.
   always_comb begin
      sign_s      = potential[SIGN_BIT];
      exp_s       = potential[EXP_MSB:EXP_LSB];
      mant_s      = {1'b1, potential[FRAC_W-1:0]};
      shifted_s   = mant_s >> decay_rate;
      diff_s      = mant_s - shifted_s;
      norm_frac_s = diff_s[FRAC_W-1:0];
      norm_exp_s  = exp_s;
      result      = potential;

      // For k>=1 the difference is at least half of m, so one left shift
      // always restores the hidden bit.
      if (diff_s[MANT_W-1]) begin
         norm_frac_s = diff_s[FRAC_W-1:0];
         norm_exp_s  = exp_s;
      end else begin
         norm_frac_s = {diff_s[FRAC_W-2:0], 1'b0};
         norm_exp_s  = exp_s - 8'd1;
      end

      if (exp_s == EXP_MAX) begin
         result = potential;
      end else if (exp_s == EXP_ZERO) begin
         result = signed_zero(sign_s);
      end else if (decay_rate == 5'd0) begin
         result = signed_zero(sign_s);
      end else if (decay_rate >= DECAY_NO_EFFECT) begin
         result = potential;
      end else if (norm_exp_s == EXP_ZERO) begin
         result = signed_zero(sign_s);
      end else begin
         result = {sign_s, norm_exp_s, norm_frac_s};
      end
   end

endmodule

// File: rtl/potential_decay.sv
// Per-neuron leak unit. A clear pulse opens each timestep; V, k and the
// neuron address are captured on the first edge after clear drops and the
// decayed potential is registered one edge later, then held.
module potential_decay
   import snn_pkg::*;
(
   input  logic                CLK,
   input  logic                clear,
   input  logic [ADDR_W-1:0]   neuron_address_initialization,
   input  logic [DECAY_W-1:0]  decay_rate,
   input  logic [31:0]         membrane_potential_initialization,
   output logic [31:0]         output_potential_decay
);

   decay_state_e       state_r;
   decay_state_e       state_next_s;
   logic               load_operands_s;
   logic               load_result_s;

   logic [31:0]        potential_r;
   logic [DECAY_W-1:0] decay_rate_r;
   logic [ADDR_W-1:0]  address_tag_r;
   logic [31:0]        result_r;
   logic [31:0]        core_result_s;

   // The address is kept only as a tag travelling with the neuron's state.
   logic               address_tag_unused_s;
   assign address_tag_unused_s = ^address_tag_r;

   fp_decay_core u_core (
      .potential  (potential_r),
      .decay_rate (decay_rate_r),
      .result     (core_result_s)
   );

   // State register; clear forces CAPTURE from any state.
   always_ff @(posedge CLK) begin
      if (clear) begin
         state_r <= CAPTURE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and register-load strobes.
   always_comb begin
      state_next_s    = state_r;
      load_operands_s = 1'b0;
      load_result_s   = 1'b0;
      case (state_r)
         IDLE: begin
            state_next_s = IDLE;
         end
         CAPTURE: begin
            load_operands_s = 1'b1;
            state_next_s    = COMPUTE;
         end
         COMPUTE: begin
            load_result_s = 1'b1;
            state_next_s  = HOLD;
         end
         HOLD: begin
            state_next_s = HOLD;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Operand registers: sampled once per timestep so later input changes are ignored.
   always_ff @(posedge CLK) begin
      if (clear) begin
         potential_r   <= 32'h0000_0000;
         decay_rate_r  <= 5'd0;
         address_tag_r <= 12'd0;
      end else if (load_operands_s) begin
         potential_r   <= membrane_potential_initialization;
         decay_rate_r  <= decay_rate;
         address_tag_r <= neuron_address_initialization;
      end else begin
         potential_r   <= potential_r;
         decay_rate_r  <= decay_rate_r;
         address_tag_r <= address_tag_r;
      end
   end

   // Result register: zero during clear, loaded in COMPUTE, held otherwise.
   always_ff @(posedge CLK) begin
      if (clear) begin
         result_r <= 32'h0000_0000;
      end else if (load_result_s) begin
         result_r <= core_result_s;
      end else begin
         result_r <= result_r;
      end
   end

   assign output_potential_decay = result_r;

endmodule

// File: tb/tb_potential_decay.sv
// Self-checking bench: ten leak units sharing clock, clear and decay rate,
// checked against an arithmetic reference of V*(1-2^-k) with truncation.
module tb_potential_decay;

   localparam int N = 10;

   logic        CLK;
   logic        clear;
   logic [4:0]  k_in;
   logic [11:0] addr   [N];
   logic [31:0] vin    [N];
   logic [31:0] vout   [N];
   logic [31:0] expect_q [N];

   int n_checks;
   int n_fail;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   for (genvar g = 0; g < N; g++) begin : g_dut
      potential_decay u_dut (
         .CLK                               (CLK),
         .clear                             (clear),
         .neuron_address_initialization     (addr[g]),
         .decay_rate                        (k_in),
         .membrane_potential_initialization (vin[g]),
         .output_potential_decay            (vout[g])
      );
   end

   // Reference: m = 2^23 + f, d = m - floor(m / 2^k), renormalize once.
   function automatic logic [31:0] ref_decay(input logic [31:0] v, input int k);
      int    e;
      longint m;
      longint d;
      e = int'(v[30:23]);
      if (e == 255) return v;
      if (e == 0 || k == 0) return {v[31], 31'd0};
      m = 64'd8388608 + longint'(v[22:0]);
      d = m - m / (64'd1 << k);
      if (d < 64'd8388608) begin
         d = d * 2;
         e = e - 1;
      end
      if (e == 0) return {v[31], 31'd0};
      return {v[31], e[7:0], d[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] r;
      int sel;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
         0: r[30:23] = 8'd0;
         1: r[30:23] = 8'd1;
         2: r[30:23] = 8'd255;
         3: r[30:23] = 8'd254;
         default: r[30:23] = r[30:23];
      endcase
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all(input string tag, input logic use_zero);
      for (int i = 0; i < N; i++) begin
         check_eq($sformatf("%s[%0d]", tag, i), vout[i], use_zero ? 32'h0 : expect_q[i]);
      end
   endtask

   // One 4-cycle timestep; inputs are scrambled after the capture edge.
   task automatic run_timestep(input logic [4:0] kk, input string tag);
      k_in  = kk;
      for (int i = 0; i < N; i++) begin
         addr[i]     = 12'($urandom);
         expect_q[i] = ref_decay(vin[i], int'(kk));
      end
      clear = 1'b1;
      tick();
      check_all({tag, "_clr"}, 1'b1);
      clear = 1'b0;
      tick();
      check_all({tag, "_cap"}, 1'b1);
      for (int i = 0; i < N; i++) vin[i] = $urandom;
      k_in = 5'($urandom);
      tick();
      check_all({tag, "_res"}, 1'b0);
      tick();
      check_all({tag, "_hold"}, 1'b0);
   endtask

   task automatic load_list();
      vin[0] = 32'h41DEB852; vin[1] = 32'h42806B85; vin[2] = 32'h40B75C29;
      vin[3] = 32'h4228B852; vin[4] = 32'h42AEB852; vin[5] = 32'h429DEB85;
      vin[6] = 32'h4165EB85; vin[7] = 32'h4212147B; vin[8] = 32'h428E2E14;
      vin[9] = 32'h411A147B;
   endtask

   logic [31:0] keep_v;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear    = 1'b1;
      k_in     = 5'd0;
      for (int i = 0; i < N; i++) begin
         vin[i]  = 32'h0;
         addr[i] = 12'd0;
      end
      tick();

      // Ten-neuron list at k=8 over several timesteps
      for (int t = 0; t < 4; t++) begin
         load_list();
         run_timestep(5'd8, "list_k8");
         check_eq("k8_27p84", vout[0], 32'h41DDD99A);
         check_eq("k8_5p73",  vout[2], 32'h40B6A4CD);
      end

      // Normalization: exact halving
      load_list();
      run_timestep(5'd1, "k1");
      check_eq("k1_norm", vout[0], 32'h415EB852);

      // k=0 flushes to signed zero
      load_list();
      vin[0] = 32'hC228B852;
      run_timestep(5'd0, "k0");
      check_eq("k0_negzero", vout[0], 32'h80000000);

      // k=31 leaves normal values unchanged
      load_list();
      run_timestep(5'd31, "k31");
      check_eq("k31_same", vout[0], 32'h41DEB852);
      check_eq("k31_same9", vout[9], 32'h411A147B);

      // Special operands
      load_list();
      vin[0] = 32'h7F800000;
      vin[1] = 32'h7FC00000;
      vin[2] = 32'h00000001;
      vin[3] = 32'h80000001;
      vin[4] = 32'h00800000;
      run_timestep(5'd8, "spec");
      check_eq("inf",      vout[0], 32'h7F800000);
      check_eq("nan",      vout[1], 32'h7FC00000);
      check_eq("denorm",   vout[2], 32'h00000000);
      check_eq("negdenorm", vout[3], 32'h80000000);
      check_eq("min_norm_flush", vout[4], 32'h00000000);

      // Clear asserted during COMPUTE aborts the result
      load_list();
      keep_v = vin[0];
      k_in   = 5'd8;
      clear  = 1'b1;
      tick();
      clear  = 1'b0;
      tick();
      clear  = 1'b1;
      tick();
      check_eq("abort_zero", vout[0], 32'h0);
      tick();
      check_eq("abort_held", vout[0], 32'h0);
      vin[0] = 32'h42806B85;
      k_in   = 5'd3;
      clear  = 1'b0;
      tick();
      check_eq("abort_cap", vout[0], 32'h0);
      vin[0] = keep_v;
      tick();
      check_eq("abort_new", vout[0], ref_decay(32'h42806B85, 3));
      tick();
      check_eq("abort_hold", vout[0], ref_decay(32'h42806B85, 3));

      // Randomized timesteps
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) vin[i] = rand_fp();
         run_timestep(5'($urandom), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
